ma_wb_pipe: RTL
===============

# ma_wb_pipe

Parametrised memory-access/write-back pipeline stage for the RV32IM pipeline, extending the plain MA→WB register with valid/ready flow control, a one-entry skid buffer, synchronous flush, and a write-back result mux. It sits between the data-memory stage and the register file. Its registered write-back and forwarding outputs drive the register-file write port and the hazard/forwarding unit. A saturating stall counter supports performance debug.

## Interface
- XLEN, 32, data width of ALU result, load data and write-back value
- RADDR_W, 5, destination register index width
- CNT_W, 16, width of saturating stall counter
- CLK  input  1  rising-edge clock
- RESETn  input  1  asynchronous, active-low reset
- in_valid  input  1  MA stage presents a valid instruction
- in_ready  output  1  stage can accept this cycle
- flush  input  1  synchronous kill of all held entries
- MUX3_select  input  1  1 = write back read_data, 0 = write back ALU_out
- regwrite_enable  input  1  instruction writes the register file
- ALU_out  input  XLEN  ALU result
- read_data  input  XLEN  data-memory load result
- rd  input  RADDR_W  destination register
- out_valid  output  1  head entry valid
- out_ready  input  1  WB consumer accepts head entry
- wb_we  output  1  register-file write strobe
- wb_rd  output  RADDR_W  head entry destination
- wb_data  output  XLEN  head entry selected result
- fwd_valid  output  1  head entry will write a non-zero register
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main entry (head) and skid entry. Each holds MUX3_select, regwrite_enable, ALU_out, read_data and rd, plus a valid bit.
- State is encoded by the valid bits:
  - EMPTY: neither entry valid.
  - FULL: main valid, skid empty.
  - SKID: both entries valid.
- Handshakes:
  - accept = in_valid & in_ready.
  - retire = out_valid & out_ready.
  - in_ready = !skid_valid. It is a function of state only and never depends on in_valid or out_ready.
- Transitions:
  - EMPTY: accept → FULL, with main loaded from the inputs.
  - FULL, accept & retire → FULL, with main replaced by the inputs.
  - FULL, accept & !retire → SKID, with skid loaded from the inputs.
  - FULL, !accept & retire → EMPTY.
  - SKID: retire → FULL, with main loaded from skid. in_ready=0, so no accept is possible.
  - Any other case holds state.
- Flush:
  - Highest priority after reset. Both valid bits clear on the next edge.
  - An accept in the same cycle is discarded.
  - Payload registers need not clear.
- Output decode (all from the main entry):
  - out_valid = main_valid.
  - wb_data = MUX3_select ? read_data : ALU_out.
  - wb_rd = rd.
  - fwd_valid = main_valid & regwrite_enable & (rd != 0).
  - wb_we = fwd_valid & out_ready. Writes to x0 are never issued.
- Stall counter:
  - Increments each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset; flush does not clear it.
- Reset (RESETn=0, asynchronous):
  - Both valid bits cleared and all payload registers cleared.
  - stall_cnt = 0.
  - Resulting outputs: out_valid=0, wb_we=0, fwd_valid=0, wb_rd=0, wb_data=0, in_ready=1.
- Reset deassertion takes effect at the first CLK edge after RESETn rises.

## Timing
- Latency: an instruction accepted at edge N appears at out_valid/wb_* after edge N (one cycle), provided main was empty or retiring.
- Throughput: one instruction per cycle when out_ready is held at 1. The skid entry is never used in that case.
- Back-pressure:
  - One out_ready=0 cycle while FULL with accept moves the stage to SKID.
  - in_ready drops the following cycle. It rises again one cycle after the SKID→FULL retire.
- Ordering: strict FIFO order. The skid entry always drains into main before any new input.
- wb_data, wb_rd and fwd_valid change only on CLK edges and are stable for the whole cycle.
- wb_we and out_valid may be sampled combinationally by the register file in the same cycle.
- An unconsumed entry holds its payload unchanged while out_ready=0.

## Test plan
- Reset: hold RESETn=0 mid-stream with both entries valid → out_valid=0, wb_we=0, in_ready=1 and stall_cnt=0 immediately, without waiting for CLK.
- Streaming: 4 back-to-back accepts with out_ready=1 and ALU_out=0x10,0x20,0x30,0x40, MUX3_select=0, rd=1..4 → wb_data 0x10..0x40 on consecutive cycles, each one cycle after its accept; in_ready stays 1.
- Load select and x0: accept MUX3_select=1, read_data=0xDEADBEEF, ALU_out=0x1, rd=5 → wb_data=0xDEADBEEF and wb_we=1. Then regwrite_enable=1 with rd=0 → fwd_valid=0 and wb_we=0.
- Skid:
  - Stimulus: accept A, then out_ready=0 for 3 cycles while presenting B and C.
  - Required: B enters skid; in_ready=0 for the next 3 cycles, so C is not accepted; stall_cnt=3.
  - Then raise out_ready: order A, B, C is preserved with no loss or duplication.
- Flush: in SKID state, assert flush together with in_valid=1 → next cycle out_valid=0 and in_ready=1, with the same-cycle input dropped; stall_cnt unchanged.
- Saturation: with CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt stops at 15.

Source files
------------

// File: rtl/ma_wb_pipe_if.sv
// MA->WB stage bus: upstream valid/ready payload, downstream write-back/forwarding
// view and the stall debug counter.
interface ma_wb_pipe_if #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic               flush;
    logic               MUX3_select;
    logic               regwrite_enable;
    logic [XLEN-1:0]    ALU_out;
    logic [XLEN-1:0]    read_data;
    logic [RADDR_W-1:0] rd;
    logic               out_valid;
    logic               out_ready;
    logic               wb_we;
    logic [RADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               fwd_valid;
    logic [CNT_W-1:0]   stall_cnt;

    modport master (
        output in_valid, flush, MUX3_select, regwrite_enable, ALU_out, read_data, rd,
               out_ready,
        input  in_ready, out_valid, wb_we, wb_rd, wb_data, fwd_valid, stall_cnt
    );

    modport slave (
        input  in_valid, flush, MUX3_select, regwrite_enable, ALU_out, read_data, rd,
               out_ready,
        output in_ready, out_valid, wb_we, wb_rd, wb_data, fwd_valid, stall_cnt
    );
endinterface

// File: rtl/ma_wb_pipe.sv
// Memory-access/write-back pipeline register with one-entry skid buffer,
// synchronous flush, write-back result mux and saturating stall counter.
module ma_wb_pipe #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5,
    parameter int unsigned CNT_W   = 16
) (
    input logic          CLK,
    input logic          RESETn,
    ma_wb_pipe_if.slave  bus
);
    typedef struct packed {
        logic               sel;
        logic               we;
        logic [XLEN-1:0]    alu;
        logic [XLEN-1:0]    rdata;
        logic [RADDR_W-1:0] rd;
    } entry_t;

    // Encoding doubles as {skid_valid, main_valid}.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        FULL  = 2'b01,
        SKID  = 2'b11
    } state_t;

    state_t           state, state_nxt;
    entry_t           main_q, skid_q, in_entry;
    logic             main_valid, skid_valid;
    logic             in_ready_w, accept, retire, fwd_w;
    logic             load_main_in, load_main_skid, load_skid;
    logic [CNT_W-1:0] stall_q;

    assign in_entry = '{sel:   bus.MUX3_select,
                        we:    bus.regwrite_enable,
                        alu:   bus.ALU_out,
                        rdata: bus.read_data,
                        rd:    bus.rd};

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == SKID);
    assign in_ready_w = !skid_valid;
    assign accept     = bus.in_valid & in_ready_w;
    assign retire     = main_valid & bus.out_ready;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state <= EMPTY;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt    = FULL;
                        load_main_in = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && retire) begin
                        load_main_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = SKID;
                        load_skid = 1'b1;
                    end else if (retire) begin
                        state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    if (retire) begin
                        state_nxt      = FULL;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in)        main_q <= in_entry;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_entry;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            stall_q <= '0;
        else if (main_valid && !bus.out_ready && (stall_q != '1))
            stall_q <= stall_q + CNT_W'(1);
    end

    assign fwd_w         = main_valid & main_q.we & (main_q.rd != '0);
    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = main_valid;
    assign bus.wb_data   = main_q.sel ? main_q.rdata : main_q.alu;
    assign bus.wb_rd     = main_q.rd;
    assign bus.fwd_valid = fwd_w;
    assign bus.wb_we     = fwd_w & bus.out_ready;
    assign bus.stall_cnt = stall_q;
endmodule
